// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a 16x8 1R1W SRAM macro; 2-entry show-ahead output buffer, 2-cycle empty-to-valid latency.
// Full-rate valid/ready on both sides; s_ready drops when the SRAM is full, reads stall when the output buffer would overflow.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  fill_cnt,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH:0] SRAM_FULL = DEPTH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wptr, wptr_nxt, rptr, rptr_nxt;
  logic [ADDR_WIDTH:0]   sram_cnt, sram_cnt_nxt;
  logic                  infl, infl_nxt;
  logic [1:0]            ob_cnt, ob_cnt_nxt;
  logic [DATA_WIDTH-1:0] ob [2];
  logic [DATA_WIDTH-1:0] ob_nxt [2];
  logic [CNT_WIDTH-1:0]  fill_q, fill_nxt;
  logic                  wr, rd, pop, cap_hi;
  logic [2:0]            occ;

  assign s_ready = rst_n & ~flush & (sram_cnt != SRAM_FULL);
  assign wr      = s_valid & s_ready;
  assign m_valid = rst_n & (ob_cnt != 2'd0);
  assign pop     = m_valid & m_ready;

  // Words that will sit in the output buffer after this edge, before any new read lands.
  assign occ = 3'(ob_cnt) + 3'(infl) - 3'(pop);
  assign rd  = rst_n & ~flush & (sram_cnt != '0) & (occ < 3'd2);

  assign cap_hi = (ob_cnt - 2'(pop)) != 2'd0;

  assign sram_csb0  = ~wr;
  assign sram_addr0 = wptr;
  assign sram_din0  = s_data;
  assign sram_csb1  = ~rd;
  assign sram_addr1 = rptr;

  assign m_data   = ob[0];
  assign fill_cnt = rst_n ? fill_q : '0;

  always_comb begin
    wptr_nxt     = wptr;
    rptr_nxt     = rptr;
    sram_cnt_nxt = sram_cnt;
    infl_nxt     = 1'b0;
    ob_cnt_nxt   = ob_cnt;
    ob_nxt       = ob;
    if (flush) begin
      wptr_nxt     = '0;
      rptr_nxt     = '0;
      sram_cnt_nxt = '0;
      ob_cnt_nxt   = 2'd0;
    end else begin
      if (wr) wptr_nxt = wptr + ADDR_WIDTH'(1);
      if (rd) rptr_nxt = rptr + ADDR_WIDTH'(1);
      case ({wr, rd})
        2'b10:   sram_cnt_nxt = sram_cnt + 1'b1;
        2'b01:   sram_cnt_nxt = sram_cnt - 1'b1;
        default: sram_cnt_nxt = sram_cnt;
      endcase
      infl_nxt = rd;
      if (pop) ob_nxt[0] = ob[1];
      // Capture lands behind whatever survives the pop, so it may overwrite the shifted slot.
      if (infl) ob_nxt[cap_hi] = sram_dout1;
      ob_cnt_nxt = ob_cnt - 2'(pop) + 2'(infl);
    end
    fill_nxt = CNT_WIDTH'(sram_cnt_nxt) + CNT_WIDTH'(infl_nxt) + CNT_WIDTH'(ob_cnt_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      sram_cnt <= '0;
      infl     <= 1'b0;
      ob_cnt   <= 2'd0;
      fill_q   <= '0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      sram_cnt <= sram_cnt_nxt;
      infl     <= infl_nxt;
      ob_cnt   <= ob_cnt_nxt;
      fill_q   <= fill_nxt;
    end
    ob <= ob_nxt;
  end

endmodule
